checker_sched: RTL and testbench
================================

Name: checker_sched

Overview:
- Sequencer that drives a single checker engine over an address range.
- Accepts one job (mode, base address, count, stride, per-check timeout) from the checker control interface.
- Issues one cstart per address, waits for the matching cend and inspects cctrl; stops on the first failure, timeout or abort.
- Reports status with a one-cycle done pulse. Sits between the CSR control interface and the checker engines.

Parameters:
TIMEOUT_W, 16, width of the per-check timeout counter and job_timeout input
CNT_W, 16, width of job_count, fail_idx and pass_cnt

Ports:
sys_clk  in  1  system clock; all logic on rising edge
sys_rst  in  1  reset, synchronous, active-low (0 = reset)
job_valid  in  1  job request
job_ready  out  1  scheduler can accept a job (high only in IDLE)
job_mode  in  2  checker mode forwarded on cmode
job_base  in  64  first check address
job_count  in  CNT_W  number of checks; 0 = empty job
job_stride  in  16  address increment per check (unsigned, zero-extended)
job_timeout  in  TIMEOUT_W  max cycles in WAIT per check; 0 = no timeout
abort  in  1  cancel running job
cmode  out  2  mode to engine, held for whole job
cstart  out  1  one-cycle start strobe to engine
caddr  out  64  address of current check, valid while busy
cend  in  1  engine completion strobe
cctrl  in  8  engine result, sampled with cend; 0 = pass
busy  out  1  high in ISSUE/WAIT/FINISH
done  out  1  one-cycle pulse at job completion
status  out  2  0 OK, 1 FAIL, 2 TIMEOUT, 3 ABORT; held until next job accepted
fail_idx  out  CNT_W  index of failing/timed-out/aborted check
fail_ctrl  out  8  cctrl of failing check
pass_cnt  out  CNT_W  checks passed in current/last job

Behaviour:
- Reset (sys_rst=0 at a clock edge):
  - State goes to IDLE.
  - cstart, done, busy, cmode, caddr, status, fail_idx, fail_ctrl, pass_cnt all 0.
  - job_ready is 1 from the first cycle after reset deasserts.
  - Reset mid-job abandons the job silently: no done pulse.
- State IDLE:
  - job_ready=1.
  - Accept on job_valid at the edge: latch mode/base/count/stride/timeout; clear status, fail_idx, fail_ctrl, pass_cnt; set idx=0.
  - If count==0, go to FINISH (status OK). Otherwise go to ISSUE.
  - abort and cend are ignored in IDLE.
- State ISSUE (one cycle):
  - cstart=1, caddr=base+idx*stride.
  - Clear the timer and go to WAIT.
  - cend in ISSUE is ignored.
- State WAIT:
  - Timer increments each cycle.
  - Priority, highest first: abort > cend > timeout.
  - abort: status=ABORT, fail_idx=idx, go to FINISH.
  - cend with cctrl!=0: status=FAIL, fail_idx=idx, fail_ctrl=cctrl, go to FINISH.
  - cend with cctrl==0: pass_cnt+1, idx+1, caddr+=stride (mod 2^64, wraps silently). If idx+1==count, go to FINISH (OK); otherwise go to ISSUE.
  - Timeout: job_timeout!=0 and timer==job_timeout-1 with no cend gives status=TIMEOUT, fail_idx=idx, go to FINISH. cend on the expiry cycle counts as completion.
- State FINISH (one cycle):
  - done=1, busy=1, then go to IDLE.
  - abort in FINISH is ignored; status is unchanged.
- Timing:
  - Latency from accept at edge N: cstart high cycle N+1.
  - cend at edge M gives the next cstart at M+1, or done at M+1 for the last check.
  - Minimum per-check period is 2 cycles + engine latency.
- Widths and holding:
  - idx/pass_cnt are CNT_W wide. count=2^CNT_W-1 is legal; no overflow is possible.
  - cmode and caddr keep their last values after done until the next accept.

Test Plan:
- Reset with sys_rst=0 for 3 cycles, then 1 -> all outputs 0, job_ready=1 on first cycle after release; cend/abort pulses in IDLE produce no change.
- Job base=0x1000, count=3, stride=0x40, timeout=0; engine returns cend, cctrl=0 after 2 cycles each -> cstart at caddr 0x1000, 0x1040, 0x1080; done one cycle after third cend; status=0, pass_cnt=3.
- Same job, second cend with cctrl=0x5A -> no third cstart; status=1, fail_idx=1, fail_ctrl=0x5A, pass_cnt=1, single done pulse.
- timeout=4, engine never responds -> done 4 WAIT cycles after cstart, status=2, fail_idx=0. Repeat with cend on the 4th WAIT cycle -> counted as pass.
- count=0 -> no cstart, done on cycle after accept, status=0. Also base=0xFFFF_FFFF_FFFF_FFC0, stride=0x40, count=2 -> second caddr=0x0.
- abort and cend on the same WAIT cycle -> status=3, pass_cnt unchanged. Reset asserted mid-WAIT -> no done, IDLE next cycle, job_ready=1.

Source files
------------

// File: rtl/checker_sched.sv
`default_nettype none
// ============================================================================
// Module  : checker_sched
// Brief   : Runs one checker engine over an address range, one check per
//           address, stopping on the first failure, timeout or abort.
// Revision: 1.0 - initial release
// ============================================================================
module checker_sched #(
    parameter int TIMEOUT_W = 16,
    parameter int CNT_W     = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [1:0]           job_mode,
    input  logic [63:0]          job_base,
    input  logic [CNT_W-1:0]     job_count,
    input  logic [15:0]          job_stride,
    input  logic [TIMEOUT_W-1:0] job_timeout,
    input  logic                 abort,
    output logic [1:0]           cmode,
    output logic                 cstart,
    output logic [63:0]          caddr,
    input  logic                 cend,
    input  logic [7:0]           cctrl,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           status,
    output logic [CNT_W-1:0]     fail_idx,
    output logic [7:0]           fail_ctrl,
    output logic [CNT_W-1:0]     pass_cnt
);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_ISSUE  = 2'd1;
    localparam logic [1:0] c_S_WAIT   = 2'd2;
    localparam logic [1:0] c_S_FINISH = 2'd3;

    localparam logic [1:0] c_ST_OK      = 2'd0;
    localparam logic [1:0] c_ST_FAIL    = 2'd1;
    localparam logic [1:0] c_ST_TIMEOUT = 2'd2;
    localparam logic [1:0] c_ST_ABORT   = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [1:0]           r_mode;
    logic [63:0]          r_caddr;
    logic [CNT_W-1:0]     r_count;
    logic [15:0]          r_stride;
    logic [TIMEOUT_W-1:0] r_timeout;
    logic [TIMEOUT_W-1:0] r_timer;
    logic [CNT_W-1:0]     r_idx;
    logic [CNT_W-1:0]     r_pass_cnt;
    logic [1:0]           r_status;
    logic [CNT_W-1:0]     r_fail_idx;
    logic [7:0]           r_fail_ctrl;

    logic [CNT_W-1:0]     w_idx_inc;
    logic                 w_last;
    logic                 w_timer_exp;

    assign w_idx_inc   = r_idx + CNT_W'(1);
    assign w_last      = (w_idx_inc == r_count);
    assign w_timer_exp = (r_timeout != '0) && (r_timer == r_timeout - TIMEOUT_W'(1));

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Abort outranks cend, and cend outranks an expiring timer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (job_valid) begin
                    w_state_nxt = (job_count == '0) ? c_S_FINISH : c_S_ISSUE;
                end
            end
            c_S_ISSUE: w_state_nxt = c_S_WAIT;
            c_S_WAIT: begin
                if (abort) begin
                    w_state_nxt = c_S_FINISH;
                end else if (cend) begin
                    w_state_nxt = ((cctrl != 8'd0) || w_last) ? c_S_FINISH : c_S_ISSUE;
                end else if (w_timer_exp) begin
                    w_state_nxt = c_S_FINISH;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        job_ready = (r_state == c_S_IDLE);
        cstart    = (r_state == c_S_ISSUE);
        busy      = (r_state != c_S_IDLE);
        done      = (r_state == c_S_FINISH);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            r_mode      <= '0;
            r_caddr     <= '0;
            r_count     <= '0;
            r_stride    <= '0;
            r_timeout   <= '0;
            r_timer     <= '0;
            r_idx       <= '0;
            r_pass_cnt  <= '0;
            r_status    <= c_ST_OK;
            r_fail_idx  <= '0;
            r_fail_ctrl <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (job_valid) begin
                        r_mode      <= job_mode;
                        r_caddr     <= job_base;
                        r_count     <= job_count;
                        r_stride    <= job_stride;
                        r_timeout   <= job_timeout;
                        r_idx       <= '0;
                        r_pass_cnt  <= '0;
                        r_status    <= c_ST_OK;
                        r_fail_idx  <= '0;
                        r_fail_ctrl <= '0;
                    end
                end
                c_S_ISSUE: r_timer <= '0;
                c_S_WAIT: begin
                    r_timer <= r_timer + TIMEOUT_W'(1);
                    if (abort) begin
                        r_status   <= c_ST_ABORT;
                        r_fail_idx <= r_idx;
                    end else if (cend) begin
                        if (cctrl != 8'd0) begin
                            r_status    <= c_ST_FAIL;
                            r_fail_idx  <= r_idx;
                            r_fail_ctrl <= cctrl;
                        end else begin
                            // caddr tracks base + idx*stride incrementally; wraps mod 2^64
                            r_pass_cnt <= r_pass_cnt + CNT_W'(1);
                            r_idx      <= w_idx_inc;
                            r_caddr    <= r_caddr + {48'd0, r_stride};
                        end
                    end else if (w_timer_exp) begin
                        r_status   <= c_ST_TIMEOUT;
                        r_fail_idx <= r_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmode     = r_mode;
    assign caddr     = r_caddr;
    assign status    = r_status;
    assign fail_idx  = r_fail_idx;
    assign fail_ctrl = r_fail_ctrl;
    assign pass_cnt  = r_pass_cnt;

endmodule
`default_nettype wire

// File: tb/tb_checker_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_checker_sched
// Brief   : Table-driven bench for checker_sched with a small engine model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_checker_sched;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [1:0]  job_mode = '0;
    logic [63:0] job_base = '0;
    logic [15:0] job_count = '0;
    logic [15:0] job_stride = '0;
    logic [15:0] job_timeout = '0;
    logic        abort = 1'b0;
    logic [1:0]  cmode;
    logic        cstart;
    logic [63:0] caddr;
    logic        cend = 1'b0;
    logic [7:0]  cctrl = '0;
    logic        busy;
    logic        done;
    logic [1:0]  status;
    logic [15:0] fail_idx;
    logic [7:0]  fail_ctrl;
    logic [15:0] pass_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 sys_clk = ~sys_clk;

    checker_sched #(.TIMEOUT_W(16), .CNT_W(16)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_mode(job_mode),
        .job_base(job_base), .job_count(job_count), .job_stride(job_stride),
        .job_timeout(job_timeout), .abort(abort), .cmode(cmode),
        .cstart(cstart), .caddr(caddr), .cend(cend), .cctrl(cctrl),
        .busy(busy), .done(done), .status(status), .fail_idx(fail_idx),
        .fail_ctrl(fail_ctrl), .pass_cnt(pass_cnt)
    );

    // lat = cycles from cstart to cend (0 = engine never answers);
    // fail_at/abort_at = check index that fails / gets aborted (-1 = none).
    typedef struct {
        logic [1:0]  mode;
        logic [63:0] base;
        logic [15:0] count;
        logic [15:0] stride;
        logic [15:0] tmo;
        int          lat;
        int          fail_at;
        logic [7:0]  fctrl;
        int          abort_at;
        logic [1:0]  e_status;
        logic [15:0] e_fidx;
        logic [7:0]  e_fctrl;
        logic [15:0] e_pass;
        int          e_starts;
        int          e_done_cyc;
    } vec_t;

    localparam int NVEC = 7;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic run_job(input vec_t v, input int id);
        int          pend;
        int          nst;
        int          cidx;
        bit          seen_done;
        logic [63:0] eaddr;
        chk($sformatf("v%0d ready", id), 64'(job_ready), 64'd1);
        job_valid   = 1'b1;
        job_mode    = v.mode;
        job_base    = v.base;
        job_count   = v.count;
        job_stride  = v.stride;
        job_timeout = v.tmo;
        tick();
        job_valid = 1'b0;
        pend = -1;
        nst = 0;
        seen_done = 1'b0;
        for (int cyc = 1; cyc <= 500 && !seen_done; cyc++) begin
            cend  = 1'b0;
            abort = 1'b0;
            cctrl = 8'h00;
            if (done) begin
                seen_done = 1'b1;
                chk($sformatf("v%0d done_cycle", id), 64'(cyc), 64'(v.e_done_cyc));
                chk($sformatf("v%0d busy_at_done", id), 64'(busy), 64'd1);
            end else begin
                if (cstart) begin
                    eaddr = v.base + 64'(nst) * {48'd0, v.stride};
                    chk($sformatf("v%0d caddr[%0d]", id, nst), caddr, eaddr);
                    chk($sformatf("v%0d cmode", id), 64'(cmode), 64'(v.mode));
                    nst++;
                    pend = v.lat;
                end else if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        cidx = nst - 1;
                        cend = 1'b1;
                        if (cidx == v.abort_at) abort = 1'b1;
                        if (cidx == v.fail_at)  cctrl = v.fctrl;
                    end
                end
                tick();
            end
        end
        cend  = 1'b0;
        abort = 1'b0;
        cctrl = 8'h00;
        chk($sformatf("v%0d done_seen", id), 64'(seen_done), 64'd1);
        chk($sformatf("v%0d starts", id), 64'(nst), 64'(v.e_starts));
        chk($sformatf("v%0d status", id), 64'(status), 64'(v.e_status));
        chk($sformatf("v%0d fail_idx", id), 64'(fail_idx), 64'(v.e_fidx));
        chk($sformatf("v%0d fail_ctrl", id), 64'(fail_ctrl), 64'(v.e_fctrl));
        chk($sformatf("v%0d pass_cnt", id), 64'(pass_cnt), 64'(v.e_pass));
        tick();
        chk($sformatf("v%0d done_single", id), 64'(done), 64'd0);
        chk($sformatf("v%0d idle_busy", id), 64'(busy), 64'd0);
        chk($sformatf("v%0d idle_ready", id), 64'(job_ready), 64'd1);
        chk($sformatf("v%0d status_hold", id), 64'(status), 64'(v.e_status));
        chk($sformatf("v%0d cmode_hold", id), 64'(cmode), 64'(v.mode));
    endtask

    initial begin
        int dones;
        //            mode  base                    cnt  stride  tmo  lat fail fctrl abrt  st   fidx fctrl pass strt cyc
        vecs[0] = '{2'd1, 64'h1000,               16'd3, 16'h40, 16'd0, 2, -1, 8'h00, -1, 2'd0, 16'd0, 8'h00, 16'd3, 3, 10};
        vecs[1] = '{2'd2, 64'h1000,               16'd3, 16'h40, 16'd0, 2,  1, 8'h5A, -1, 2'd1, 16'd1, 8'h5A, 16'd1, 2, 7};
        vecs[2] = '{2'd3, 64'h2000,               16'd3, 16'h10, 16'd4, 0, -1, 8'h00, -1, 2'd2, 16'd0, 8'h00, 16'd0, 1, 6};
        vecs[3] = '{2'd0, 64'h3000,               16'd2, 16'h08, 16'd4, 4, -1, 8'h00, -1, 2'd0, 16'd0, 8'h00, 16'd2, 2, 11};
        vecs[4] = '{2'd1, 64'h4000,               16'd0, 16'h40, 16'd0, 1, -1, 8'h00, -1, 2'd0, 16'd0, 8'h00, 16'd0, 0, 1};
        vecs[5] = '{2'd2, 64'hFFFF_FFFF_FFFF_FFC0, 16'd2, 16'h40, 16'd0, 1, -1, 8'h00, -1, 2'd0, 16'd0, 8'h00, 16'd2, 2, 5};
        vecs[6] = '{2'd3, 64'h5000,               16'd3, 16'h20, 16'd0, 2, -1, 8'h00,  1, 2'd3, 16'd1, 8'h00, 16'd1, 2, 7};

        // Reset held for three edges, then released.
        sys_rst = 1'b0;
        repeat (3) tick();
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst cstart", 64'(cstart), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        sys_rst = 1'b1;
        tick();
        chk("rel ready", 64'(job_ready), 64'd1);
        chk("rel caddr", caddr, 64'd0);
        chk("rel cmode", 64'(cmode), 64'd0);
        chk("rel status", 64'(status), 64'd0);
        chk("rel fail_idx", 64'(fail_idx), 64'd0);
        chk("rel fail_ctrl", 64'(fail_ctrl), 64'd0);
        chk("rel pass_cnt", 64'(pass_cnt), 64'd0);

        // cend/abort in IDLE must be ignored.
        cend = 1'b1; cctrl = 8'hFF; abort = 1'b1;
        tick();
        cend = 1'b0; cctrl = 8'h00; abort = 1'b0;
        chk("idle_ign busy", 64'(busy), 64'd0);
        chk("idle_ign status", 64'(status), 64'd0);
        chk("idle_ign fail_ctrl", 64'(fail_ctrl), 64'd0);
        chk("idle_ign pass_cnt", 64'(pass_cnt), 64'd0);
        tick();
        chk("idle_ign done", 64'(done), 64'd0);

        for (int i = 0; i < NVEC; i++) run_job(vecs[i], i);

        // Reset in the middle of WAIT abandons the job with no done pulse.
        job_valid = 1'b1; job_mode = 2'd2; job_base = 64'h6000;
        job_count = 16'd2; job_stride = 16'h4; job_timeout = 16'd0;
        tick();
        job_valid = 1'b0;
        chk("midrst cstart", 64'(cstart), 64'd1);
        tick();
        tick();
        chk("midrst in_wait busy", 64'(busy), 64'd1);
        sys_rst = 1'b0;
        tick();
        sys_rst = 1'b1;
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst done", 64'(done), 64'd0);
        chk("midrst ready", 64'(job_ready), 64'd1);
        chk("midrst caddr", caddr, 64'd0);
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            if (done) dones++;
            tick();
        end
        chk("midrst no_done", 64'(dones), 64'd0);
        chk("midrst idle_ready", 64'(job_ready), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
